// File: rtl/silu_stream_ctrl.sv
// silu_stream_ctrl: job sequencer streaming LEN elements through a registered silu datapath
module silu_stream_ctrl #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_bypass,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [I_DATA-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [I_DATA-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int BIAS = (1 << (I_EXP - 1)) - 1;
    localparam int F    = I_MNT + 1;
    localparam int AW   = F + 3;
    localparam int PW   = I_MNT + F + 2;
    localparam logic [I_EXP-1:0] E_LO  = I_EXP'(BIAS - 1);
    localparam logic [I_EXP-1:0] E_BIG = I_EXP'(BIAS + 2);
    localparam logic [AW-1:0]    FOUR  = {3'd4, {F{1'b0}}};
    localparam logic [F:0]       ONE   = {1'b1, {F{1'b0}}};

    state_t            state, state_nx;
    logic [LEN_W-1:0]  len, in_cnt, out_cnt;
    logic              bypass, s1_v, s2_v, s1_adv, s2_adv, cmd_hs, in_hs, out_hs;
    logic [I_DATA-1:0] s1_d, s2_d, silu_y;

    logic              x_s;
    logic [I_EXP-1:0]  x_e;
    logic [I_MNT-1:0]  x_m;
    logic [I_MNT:0]    mant;
    logic [AW-1:0]     a, d;
    logic [2*AW-1:0]   dd;
    logic [F:0]        q, sig;
    logic [PW-1:0]     p;
    int                pos, re;

    assign cmd_ready = (state == IDLE) && !abort;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = (state == RUN) && (in_cnt != len) && s1_adv;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = s2_v && out_ready;
    assign out_valid = s2_v;
    assign out_data  = s2_d;
    assign out_last  = s2_v && (out_cnt == len - LEN_W'(1));
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    // silu(x) = x * sigmoid(x), sigmoid approximated by a clamped piecewise quadratic:
    // (x+4)^2/32 on [-4,0], 1-(4-x)^2/32 on [0,4]; sigmoid runs in fixed point, the
    // product is renormalised with truncation; denormals and underflow flush to signed zero
    always_comb begin
        x_s    = s1_d[I_DATA-1];
        x_e    = s1_d[I_DATA-2 -: I_EXP];
        x_m    = s1_d[I_MNT-1:0];
        mant   = {x_e != '0, x_m};
        a      = (x_e >= E_LO) ? AW'(mant) << (x_e - E_LO) : AW'(mant) >> (E_LO - x_e);
        d      = FOUR - a;
        dd     = {{AW{1'b0}}, d} * {{AW{1'b0}}, d};
        q      = (F + 1)'(dd >> (F + 5));
        sig    = x_s ? q : ONE - q;
        p      = {{(F + 1){1'b0}}, mant} * {{(I_MNT + 1){1'b0}}, sig};
        pos    = 0;
        for (int i = 0; i < PW; i++) if (p[i]) pos = i;
        re     = int'(x_e) + pos - (I_MNT + F);
        silu_y = (x_e == '1 && x_m != '0) ? s1_d :
                 (x_e >= E_BIG) ? (x_s ? '0 : s1_d) :
                 (x_e == '0 || p == '0 || re <= 0) ? {x_s, {(I_DATA - 1){1'b0}}} :
                 {x_s, I_EXP'(re), I_MNT'((p << (PW - 1 - pos)) >> (PW - 1 - I_MNT))};
    end

    // job state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: abort wins, zero-length jobs go straight to DONE, last output handshake ends RUN
    always_comb begin
        state_nx = state;
        state_nx = abort ? IDLE :
                   (state == IDLE) ? (cmd_hs ? ((cmd_len == '0) ? DONE : RUN) : IDLE) :
                   (state == RUN)  ? ((out_hs && out_last) ? DONE : RUN) : IDLE;
    end

    // job parameters and element counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            bypass  <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (abort) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (cmd_hs) begin
            len     <= cmd_len;
            bypass  <= cmd_bypass;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            in_cnt  <= in_cnt + LEN_W'(in_hs);
            out_cnt <= out_cnt + LEN_W'(out_hs);
        end
    end

    // two-stage pipeline: s1 holds the raw element, s2 the result; s2 holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_d <= '0;
            s2_d <= '0;
        end else if (abort) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) s1_v <= in_hs;
            if (in_hs) s1_d <= in_data;
            if (s2_adv) s2_v <= s1_v;
            if (s2_adv && s1_v) s2_d <= bypass ? s1_d : silu_y;
        end
    end
endmodule

// File: tb/tb_silu_stream_ctrl.sv
// tb_silu_stream_ctrl: directed and randomized jobs checked against a real-valued silu model
module tb_silu_stream_ctrl;
    logic        clk = 0, rst_n = 1, cmd_valid = 0, cmd_bypass = 0, abort = 0;
    logic        in_valid = 0, out_ready = 0;
    logic [15:0] cmd_len = 0;
    logic [31:0] in_data = 0;
    logic        cmd_ready, in_ready, out_valid, out_last, busy, done;
    logic [31:0] out_data;
    int          nvec = 0, nfail = 0;
    logic [31:0] src[$];
    logic [31:0] got[$];

    silu_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_bypass(cmd_bypass), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        return (b[31] ? -m : m) * (2.0 ** (real'(b[30:23]) - 127.0));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 134)), 23'($urandom)};
    endfunction

    task automatic chk_silu(input logic [31:0] x, input logic [31:0] obs, input bit byp);
        real xr, s, y, diff, tol;
        bit  ok;
        if (byp) chk("bypass_data", obs, x);
        else begin
            xr = f2r(x);
            if (xr >= 4.0) chk("silu_pos_sat", obs, x);
            else if (xr <= -4.0) chk("silu_neg_sat", obs, 32'h0);
            else begin
                s    = (xr < 0.0) ? (xr + 4.0) * (xr + 4.0) / 32.0 : 1.0 - (4.0 - xr) * (4.0 - xr) / 32.0;
                y    = xr * s;
                diff = f2r(obs) - y;
                diff = (diff < 0.0) ? -diff : diff;
                tol  = ((y < 0.0) ? -y : y) * (2.0 ** -16) + (2.0 ** -20);
                ok   = diff <= tol;
                nvec++;
                assert (ok === 1'b1) else begin
                    nfail++;
                    $error("FAIL silu_value: x %h observed %h (%g) expected %g", x, obs, f2r(obs), y);
                end
            end
        end
    endtask

    // rmode: 0 out_ready high, 1 toggling, 2 random; rvalid randomises in_valid; abort_at<0 disables abort
    task automatic job(input int len, input bit byp, input int rmode, input bit rvalid, input int abort_at);
        logic [31:0] data[$];
        logic [31:0] exp_q[$];
        int          cyc_q[$];
        int          sent = 0, rcvd = 0, cyc = 0, last_out = -1;
        bit          fin = 0, stall = 0;
        logic [31:0] prev_d = 0;
        got.delete();
        for (int i = 0; i < len; i++) data.push_back(i < src.size() ? src[i] : rnd_f());
        src.delete();
        cmd_valid = 1; cmd_len = 16'(len); cmd_bypass = byp;
        #1 chk("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        chk("busy_run", busy, 1);
        while (!fin && cyc < 20 * len + 50) begin
            if (abort_at >= 0 && sent == abort_at) begin
                abort = 1; in_valid = 0; out_ready = 1;
                tick();
                abort = 0;
                chk("abort_busy", busy, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 0);
                repeat (4) begin
                    tick();
                    chk("abort_no_done", done, 0);
                end
                return;
            end
            in_valid  = (sent < len) && (!rvalid || $urandom_range(0, 3) != 0);
            in_data   = (sent < len) ? data[sent] : rnd_f();
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
            #1;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
            end
            if (out_valid && !out_ready && sent - rcvd == 2) chk("full_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(data[sent]);
                cyc_q.push_back(cyc);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk_silu(exp_q[0], out_data, byp);
                    chk("out_last", out_last, rcvd == len - 1);
                    if (rmode == 0) chk("latency", cyc - cyc_q[0], 2);
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end
                got.push_back(out_data);
                rcvd++;
                last_out = cyc;
            end else if (out_valid) chk("out_last_stalled", out_last, rcvd == len - 1);
            if (done) begin
                chk("done_count", rcvd, len);
                chk("done_delay", cyc - last_out, 1);
                chk("done_no_valid", out_valid, 0);
                fin = 1;
            end
            stall  = out_valid && !out_ready;
            prev_d = out_data;
            tick();
            cyc++;
        end
        in_valid = 0;
        chk("job_finished", fin, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #1 rst_n = 0;
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        tick();
        rst_n = 1;

        src = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        job(4, 1, 0, 0, -1);
        for (int i = 0; i < 4; i++) chk("t1_word", got[i], 32'h3F800000 + 32'(i == 0 ? 0 : i == 1 ? 32'h800000 : i == 2 ? 32'hC00000 : 32'h1000000));

        src = '{32'h40A00000, 32'hC0A00000, 32'hC0000000};
        job(3, 0, 0, 0, -1);
        chk("t2_out0", got[0], 32'h40A00000);
        chk("t2_out1", got[1], 32'h00000000);
        chk("t2_out2", got[2], 32'hBE800000);

        job(8, 0, 1, 0, -1);
        job(8, 1, 1, 1, -1);

        cmd_valid = 1; cmd_len = 0; cmd_bypass = 0;
        #1 chk("len0_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        chk("len0_busy", busy, 1);
        chk("len0_done", done, 1);
        chk("len0_out_valid", out_valid, 0);
        tick();
        chk("len0_idle_busy", busy, 0);
        chk("len0_idle_done", done, 0);
        chk("len0_cmd_ready_after", cmd_ready, 1);

        job(6, 0, 0, 0, 3);
        job(2, 0, 0, 0, -1);

        abort = 1; cmd_valid = 1; cmd_len = 5;
        #1 chk("abort_idle_cmd_ready", cmd_ready, 0);
        tick();
        abort = 0; cmd_valid = 0;
        chk("abort_idle_busy", busy, 0);

        repeat (12) job($urandom_range(1, 20), 1'($urandom_range(0, 1)), 2, 1, -1);
        job(10, 0, 2, 1, 4);

        cmd_valid = 1; cmd_len = 8; cmd_bypass = 0;
        tick();
        cmd_valid = 0; in_valid = 1; in_data = rnd_f(); out_ready = 0;
        repeat (3) tick();
        chk("rst6_full_valid", out_valid, 1);
        chk("rst6_full_in_ready", in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("rst6_out_valid", out_valid, 0);
        chk("rst6_out_data", out_data, 0);
        chk("rst6_out_last", out_last, 0);
        chk("rst6_busy", busy, 0);
        chk("rst6_done", done, 0);
        chk("rst6_in_ready", in_ready, 0);
        @(posedge clk);
        #1 chk("rst6_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1; in_valid = 0;
        job(5, 0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
